// File: rtl/demux_8bit_pkg.sv
// rtl/demux_8bit_pkg.sv - shared widths and data word type for the 8-bit demux
package demux_8bit_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef logic [DEF_WIDTH-1:0] data_t;

endpackage

// File: rtl/demux_1bit.sv
// rtl/demux_1bit.sv - single-bit 1-to-2 demux cell, plain AND gating so X on select propagates naturally
module demux_1bit (
    input  logic in,
    input  logic select,
    output logic a,
    output logic b
);

    assign a = in & ~select;
    assign b = in &  select;

endmodule

// File: rtl/demux_8bit.sv
// rtl/demux_8bit.sv - 1-to-2 word demux with registered shadow copies and saturating routing counters
module demux_8bit
    import demux_8bit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             select,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outA_q,
    output logic [WIDTH-1:0] outB_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        demux_1bit uBit (
            .in    (in[i]),
            .select(select),
            .a     (outA[i]),
            .b     (outB[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outA_q <= '0;
            outB_q <= '0;
            sel_q  <= 1'b0;
        end else if (en) begin
            outA_q <= outA;
            outB_q <= outB;
            sel_q  <= select;
        end
    end

    // Counters stick at all-ones so a long run never reads back as a small count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (en) begin
            if (!select && !(&cnt_a)) cnt_a <= cnt_a + CNT_W'(1);
            if (select && !(&cnt_b))  cnt_b <= cnt_b + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_8bit.sv
// tb/tb_demux_8bit.sv - randomized and directed self-checking bench for demux_8bit
module tb_demux_8bit;
    import demux_8bit_pkg::*;

    logic        clk = 1'b0;
    bit          clkOn = 1'b0;
    logic        reset_n;
    logic        select;
    data_t       in;
    logic        en;
    data_t       outA, outB, outA_q, outB_q;
    logic        sel_q;
    logic [15:0] cnt_a, cnt_b;
    data_t       sOutA, sOutB, sOutA_q, sOutB_q;
    logic        sSel_q;
    logic [3:0]  sCnt_a, sCnt_b;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: routed words and raw routing counts since last reset.
    data_t expA_q, expB_q;
    logic  expSel_q;
    int    nA, nB;

    demux_8bit dut (
        .clk(clk), .reset_n(reset_n), .select(select), .in(in), .en(en),
        .outA(outA), .outB(outB), .outA_q(outA_q), .outB_q(outB_q),
        .sel_q(sel_q), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    demux_8bit #(.CNT_W(4)) dutSat (
        .clk(clk), .reset_n(reset_n), .select(select), .in(in), .en(en),
        .outA(sOutA), .outB(sOutB), .outA_q(sOutA_q), .outB_q(sOutB_q),
        .sel_q(sSel_q), .cnt_a(sCnt_a), .cnt_b(sCnt_b)
    );

    always #5 if (clkOn) clk = ~clk;

    function automatic data_t routeTo(bit wantB, logic sel, data_t d);
        return (sel == wantB) ? d : '0;
    endfunction

    function automatic int sat(int n, int maxVal);
        return (n > maxVal) ? maxVal : n;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkComb(string tag);
        check({tag, ".outA"}, 32'(outA), 32'(routeTo(1'b0, select, in)));
        check({tag, ".outB"}, 32'(outB), 32'(routeTo(1'b1, select, in)));
    endtask

    task automatic checkRegs(string tag);
        check({tag, ".outA_q"}, 32'(outA_q), 32'(expA_q));
        check({tag, ".outB_q"}, 32'(outB_q), 32'(expB_q));
        check({tag, ".sel_q"},  32'(sel_q),  32'(expSel_q));
        check({tag, ".cnt_a"},  32'(cnt_a),  32'(sat(nA, 65535)));
        check({tag, ".cnt_b"},  32'(cnt_b),  32'(sat(nB, 65535)));
        check({tag, ".s.cnt_a"}, 32'(sCnt_a), 32'(sat(nA, 15)));
        check({tag, ".s.cnt_b"}, 32'(sCnt_b), 32'(sat(nB, 15)));
        check({tag, ".s.outB_q"}, 32'(sOutB_q), 32'(expB_q));
    endtask

    task automatic modelReset();
        expA_q = '0; expB_q = '0; expSel_q = 1'b0; nA = 0; nB = 0;
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        if (en) begin
            expA_q = routeTo(1'b0, select, in);
            expB_q = routeTo(1'b1, select, in);
            expSel_q = select;
            if (select) nB++; else nA++;
        end
        #1;
        checkRegs(tag);
    endtask

    task automatic asyncReset(string tag);
        reset_n = 1'b0;
        modelReset();
        #1;
        checkRegs(tag);
        reset_n = 1'b1;
    endtask

    logic  tSel [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    data_t tIn  [8] = '{8'h00, 8'h00, 8'h12, 8'h12, 8'h98, 8'h98, 8'hAA, 8'h55};
    data_t tA   [8] = '{8'h00, 8'h00, 8'h12, 8'h00, 8'h98, 8'h00, 8'hAA, 8'h00};
    data_t tB   [8] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h00, 8'h98, 8'h00, 8'h55};

    initial begin
        // Reset with no clock running; combinational path still live.
        reset_n = 1'b0; en = 1'b0; select = 1'b1; in = 8'h55;
        modelReset();
        #1;
        checkRegs("reset");
        check("reset.outB", 32'(outB), 32'h55);
        check("reset.outA", 32'(outA), 32'h00);

        for (int i = 0; i < 8; i++) begin
            select = tSel[i]; in = tIn[i];
            #1;
            check($sformatf("tt%0d.outA", i), 32'(outA), 32'(tA[i]));
            check($sformatf("tt%0d.outB", i), 32'(outB), 32'(tB[i]));
        end

        reset_n = 1'b1;
        clkOn = 1'b1;
        #2;

        en = 1'b1; select = 1'b1; in = 8'h98;
        tick("reg98");
        check("reg98.outB_q", 32'(outB_q), 32'h98);
        check("reg98.cnt_b", 32'(cnt_b), 32'h1);
        en = 1'b0; in = 8'h12;
        tick("hold");
        check("hold.outB_q", 32'(outB_q), 32'h98);

        for (int i = 0; i < 200; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            select = 1'($urandom);
            in = 8'($urandom);
            #1;
            checkComb($sformatf("rnd%0d", i));
            tick($sformatf("rnd%0d", i));
        end

        #2;
        asyncReset("rst1");
        en = 1'b1; select = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in = 8'($urandom);
            tick($sformatf("sat%0d", i));
        end
        check("sat.s.cnt_a", 32'(sCnt_a), 32'hF);
        check("sat.s.cnt_b", 32'(sCnt_b), 32'h0);
        check("sat.cnt_a", 32'(cnt_a), 32'd20);

        #2;
        asyncReset("rst2");
        for (int i = 0; i < 5; i++) tick($sformatf("pre%0d", i));
        check("pre.cnt_a", 32'(cnt_a), 32'd5);
        #2;
        select = 1'b1; in = 8'h55;
        asyncReset("mid");
        check("mid.outB", 32'(outB), 32'h55);
        select = 1'b0;
        tick("resume");
        check("resume.cnt_a", 32'(cnt_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
